// File: rtl/shadow_dump_if.sv
// Handshake bundle between the shadow dump sequencer and the scan chains / consumer.
// The slave modport is the controller's view; master is the environment's view.
interface shadow_dump_if #(
    parameter int NUM_CHAINS = 3,
    parameter int CNT_W      = 16
);
    logic                  trigger;
    logic [NUM_CHAINS-1:0] chain_mask;
    logic [NUM_CHAINS-1:0] chain_data;
    logic [NUM_CHAINS-1:0] chain_vld;
    logic [NUM_CHAINS-1:0] chain_done;
    logic                  capture_en;
    logic [NUM_CHAINS-1:0] chain_dump_en;
    logic                  dout;
    logic                  dout_vld;
    logic                  busy;
    logic                  dump_done;
    logic [CNT_W-1:0]      bit_count;
    logic                  timeout_err;

    modport slave (
        input  trigger, chain_mask, chain_data, chain_vld, chain_done,
        output capture_en, chain_dump_en, dout, dout_vld, busy, dump_done,
               bit_count, timeout_err
    );

    modport master (
        output trigger, chain_mask, chain_data, chain_vld, chain_done,
        input  capture_en, chain_dump_en, dout, dout_vld, busy, dump_done,
               bit_count, timeout_err
    );
endinterface

// File: rtl/shadow_dump_ctrl.sv
// Sequences a snapshot capture and then dumps each selected shadow chain in turn,
// forwarding its serial bits on a single registered stream.
module shadow_dump_ctrl #(
    parameter int NUM_CHAINS = 3,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    shadow_dump_if.slave  bus
);
    localparam int IDX_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SELECT,
        S_DUMP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_CHAINS-1:0] pend_q, pend_d;
    logic [IDX_W-1:0]      idx_q, idx_d, low_idx;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      idle_q, idle_d;
    logic                  dout_q, dout_d;
    logic                  dvld_q, dvld_d;
    logic                  terr_q, terr_d;
    logic                  cur_vld, cur_done, cur_data;

    // Lowest pending chain wins; scan from the top so the last hit is the lowest index.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = IDX_W'(i);
        end
    end

    assign cur_vld  = bus.chain_vld[idx_q];
    assign cur_done = bus.chain_done[idx_q];
    assign cur_data = bus.chain_data[idx_q];

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        idx_d     = idx_q;
        bit_cnt_d = bit_cnt_q;
        idle_d    = idle_q;
        dout_d    = dout_q;
        dvld_d    = 1'b0;
        terr_d    = terr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.trigger) begin
                    state_d   = S_CAPTURE;
                    pend_d    = bus.chain_mask;
                    bit_cnt_d = '0;
                    terr_d    = 1'b0;
                end
            end
            S_CAPTURE: state_d = S_SELECT;
            S_SELECT: begin
                idle_d = '0;
                if (pend_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = low_idx;
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (cur_vld) begin
                    dvld_d = 1'b1;
                    dout_d = cur_data;
                    idle_d = '0;
                    if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                // Completion beats timeout; a bit arriving with done is still forwarded above.
                if (cur_done) begin
                    pend_d[idx_q] = 1'b0;
                    state_d       = S_SELECT;
                end else if (!cur_vld && idle_q == CNT_W'(TIMEOUT - 1)) begin
                    pend_d[idx_q] = 1'b0;
                    terr_d        = 1'b1;
                    state_d       = S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            idle_q    <= '0;
            dout_q    <= 1'b0;
            dvld_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            bit_cnt_q <= bit_cnt_d;
            idle_q    <= idle_d;
            dout_q    <= dout_d;
            dvld_q    <= dvld_d;
            terr_q    <= terr_d;
        end
    end

    assign bus.capture_en    = (state_q == S_CAPTURE);
    assign bus.chain_dump_en = (state_q == S_DUMP) ? (NUM_CHAINS'(1) << idx_q) : '0;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.dump_done     = (state_q == S_DONE);
    assign bus.dout          = dout_q;
    assign bus.dout_vld      = dvld_q;
    assign bus.bit_count     = bit_cnt_q;
    assign bus.timeout_err   = terr_q;
endmodule

// File: tb/tb_shadow_dump_ctrl.sv
// Directed bench for shadow_dump_ctrl: reactive chain models driven at the falling edge,
// per-scenario tasks compare recorded activity against hand-computed expectations.
module tb_shadow_dump_ctrl;
    localparam int NC = 3;
    localparam int CW = 16;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shadow_dump_if #(.NUM_CHAINS(NC), .CNT_W(CW)) bus();

    shadow_dump_ctrl #(.NUM_CHAINS(NC), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // chain models: clen = bits to send (-1 = silent forever), then done
    logic [7:0]    cbyte [NC];
    int            clen  [NC];
    int            cptr  [NC];
    bit            noise;
    bit            done_last;
    logic [NC-1:0] mask;
    int            trig_q[$];

    // activity record
    int            cap_cnt, done_cnt, first_cap, first_done, first_grant;
    logic          dbits[$];
    logic [NC-1:0] gseq[$];
    int            ghold [NC];
    logic [NC-1:0] last_g;

    task automatic clear_rec();
        cap_cnt = 0; done_cnt = 0; first_cap = -1; first_done = -1; first_grant = -1;
        dbits.delete(); gseq.delete(); last_g = '0;
        trig_q.delete(); noise = 0; done_last = 0;
        for (int ch = 0; ch < NC; ch++) begin ghold[ch] = 0; cptr[ch] = 0; clen[ch] = 0; cbyte[ch] = 8'h00; end
    endtask

    task automatic idle_inputs();
        bus.trigger = 1'b0; bus.chain_mask = '0; bus.chain_data = '0;
        bus.chain_vld = '0; bus.chain_done = '0;
    endtask

    // Cycle c: record outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic run(input int n);
        logic [NC-1:0] g, v, d, dt;
        bit t;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            g = bus.chain_dump_en;
            if (bus.capture_en) begin cap_cnt++; if (first_cap < 0) first_cap = c; end
            if (bus.dump_done) begin done_cnt++; if (first_done < 0) first_done = c; end
            if (bus.dout_vld) dbits.push_back(bus.dout);
            if (g != '0) begin
                if (first_grant < 0) first_grant = c;
                if (g != last_g) gseq.push_back(g);
                for (int ch = 0; ch < NC; ch++) if (g[ch]) ghold[ch]++;
            end
            last_g = g;
            t = 0;
            foreach (trig_q[k]) if (trig_q[k] == c) t = 1;
            v = '0; d = '0; dt = '0;
            for (int ch = 0; ch < NC; ch++) begin
                if (g[ch]) begin
                    if (cptr[ch] < clen[ch]) begin
                        v[ch] = 1'b1; dt[ch] = cbyte[ch][cptr[ch]]; cptr[ch]++;
                        if (done_last && cptr[ch] == clen[ch]) d[ch] = 1'b1;
                    end else if (clen[ch] >= 0) begin
                        d[ch] = 1'b1;
                    end
                end
            end
            if (noise && g[0]) begin v[1] = 1'b1; d[1] = 1'b1; dt[1] = 1'b1; end
            bus.trigger = t; bus.chain_mask = mask;
            bus.chain_vld = v; bus.chain_done = d; bus.chain_data = dt;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.capture_en !== 1'b0) begin errors++; $display("FAIL reset_capture_en got=%b exp=0", bus.capture_en); end
        checks++; if (bus.chain_dump_en !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=000", bus.chain_dump_en); end
        checks++; if (bus.dout !== 1'b0 || bus.dout_vld !== 1'b0) begin errors++; $display("FAIL reset_dout got=%b/%b exp=0/0", bus.dout, bus.dout_vld); end
        checks++; if (bus.busy !== 1'b0 || bus.dump_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b/%b exp=0/0", bus.busy, bus.dump_done); end
        checks++; if (bus.bit_count !== 16'd0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_cnt_err got=%0d/%b exp=0/0", bus.bit_count, bus.timeout_err); end
        rst = 1'b0;
        clear_rec(); mask = '0;
        run(3);
        checks++; if (bus.busy !== 1'b0 || cap_cnt != 0) begin errors++; $display("FAIL reset_idle got busy=%b cap=%0d exp 0/0", bus.busy, cap_cnt); end
    endtask

    task automatic test_two_chains();
        logic [15:0] got;
        clear_rec();
        mask = 3'b011; cbyte[0] = 8'hFC; cbyte[1] = 8'hEB; clen[0] = 8; clen[1] = 8;
        trig_q.push_back(0);
        run(30);
        got = '0;
        foreach (dbits[i]) if (i < 16) got[i] = dbits[i];
        checks++; if (cap_cnt != 1 || first_cap != 1) begin errors++; $display("FAIL two_capture got cnt=%0d at=%0d exp 1 at 1", cap_cnt, first_cap); end
        checks++; if (first_grant != 3) begin errors++; $display("FAIL two_first_grant got=%0d exp=3", first_grant); end
        checks++; if (gseq.size() != 2 || gseq[0] !== 3'b001 || gseq[1] !== 3'b010) begin errors++; $display("FAIL two_grant_seq got n=%0d exp 001,010", gseq.size()); end
        checks++; if (dbits.size() != 16 || got !== 16'hEBFC) begin errors++; $display("FAIL two_stream got n=%0d bits=%h exp 16 bits=ebfc", dbits.size(), got); end
        checks++; if (bus.bit_count !== 16'd16) begin errors++; $display("FAIL two_bit_count got=%0d exp=16", bus.bit_count); end
        checks++; if (done_cnt != 1 || first_done != 23) begin errors++; $display("FAIL two_dump_done got cnt=%0d at=%0d exp 1 at 23", done_cnt, first_done); end
        checks++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL two_end got err=%b busy=%b exp 0/0", bus.timeout_err, bus.busy); end
    endtask

    task automatic test_timeout();
        clear_rec();
        mask = 3'b100; clen[2] = -1;
        trig_q.push_back(0);
        run(265);
        checks++; if (ghold[2] != TO) begin errors++; $display("FAIL to_grant_hold got=%0d exp=%0d", ghold[2], TO); end
        checks++; if (gseq.size() != 1 || gseq[0] !== 3'b100) begin errors++; $display("FAIL to_grant_seq got n=%0d exp 100", gseq.size()); end
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", bus.timeout_err); end
        checks++; if (done_cnt != 1 || first_done != 259) begin errors++; $display("FAIL to_dump_done got cnt=%0d at=%0d exp 1 at 259", done_cnt, first_done); end
        checks++; if (bus.bit_count !== 16'd0 || dbits.size() != 0) begin errors++; $display("FAIL to_bits got=%0d/%0d exp=0/0", bus.bit_count, dbits.size()); end
    endtask

    task automatic test_empty_mask();
        clear_rec();
        mask = 3'b000;
        trig_q.push_back(0);
        run(8);
        checks++; if (cap_cnt != 1 || first_cap != 1) begin errors++; $display("FAIL empty_capture got cnt=%0d at=%0d exp 1 at 1", cap_cnt, first_cap); end
        checks++; if (gseq.size() != 0) begin errors++; $display("FAIL empty_grant got n=%0d exp=0", gseq.size()); end
        checks++; if (done_cnt != 1 || first_done != 3) begin errors++; $display("FAIL empty_dump_done got cnt=%0d at=%0d exp 1 at 3", done_cnt, first_done); end
        checks++; if (bus.bit_count !== 16'd0) begin errors++; $display("FAIL empty_bit_count got=%0d exp=0", bus.bit_count); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL empty_err_cleared got=%b exp=0", bus.timeout_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        clear_rec();
        mask = 3'b001; cbyte[0] = 8'h5A; clen[0] = 8; done_last = 1;
        // grant 3..10 with done on the last bit, SELECT 11, DONE 12
        trig_q.push_back(0); trig_q.push_back(5); trig_q.push_back(12);
        run(20);
        got = '0;
        foreach (dbits[i]) if (i < 8) got[i] = dbits[i];
        checks++; if (cap_cnt != 1) begin errors++; $display("FAIL b2b_capture got=%0d exp=1", cap_cnt); end
        checks++; if (done_cnt != 1 || first_done != 12) begin errors++; $display("FAIL b2b_dump_done got cnt=%0d at=%0d exp 1 at 12", done_cnt, first_done); end
        checks++; if (bus.bit_count !== 16'd8 || got !== 8'h5A) begin errors++; $display("FAIL b2b_stream got cnt=%0d bits=%h exp 8 bits=5a", bus.bit_count, got); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_noise();
        logic [7:0] got;
        clear_rec();
        mask = 3'b001; cbyte[0] = 8'hA5; clen[0] = 8; noise = 1;
        trig_q.push_back(0);
        run(20);
        got = '0;
        foreach (dbits[i]) if (i < 8) got[i] = dbits[i];
        checks++; if (gseq.size() != 1 || gseq[0] !== 3'b001) begin errors++; $display("FAIL noise_grant_seq got n=%0d exp 001", gseq.size()); end
        checks++; if (dbits.size() != 8 || got !== 8'hA5) begin errors++; $display("FAIL noise_stream got n=%0d bits=%h exp 8 bits=a5", dbits.size(), got); end
        checks++; if (done_cnt != 1 || first_done != 13) begin errors++; $display("FAIL noise_dump_done got cnt=%0d at=%0d exp 1 at 13", done_cnt, first_done); end
    endtask

    task automatic test_rst_mid_dump();
        logic [7:0] got;
        clear_rec();
        mask = 3'b001; cbyte[0] = 8'hDA; clen[0] = 8;
        trig_q.push_back(0);
        run(6);
        @(posedge clk); #2;
        checks++; if (bus.bit_count !== 16'd3 || bus.chain_dump_en !== 3'b001) begin errors++; $display("FAIL mid_pre got cnt=%0d grant=%b exp 3/001", bus.bit_count, bus.chain_dump_en); end
        rst = 1'b1; #1;
        checks++; if (bus.capture_en !== 1'b0 || bus.chain_dump_en !== 3'b000 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_async_ctl got cap=%b grant=%b busy=%b exp 0", bus.capture_en, bus.chain_dump_en, bus.busy); end
        checks++; if (bus.dout !== 1'b0 || bus.dout_vld !== 1'b0 || bus.bit_count !== 16'd0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL mid_async_data got dout=%b vld=%b cnt=%0d err=%b exp 0", bus.dout, bus.dout_vld, bus.bit_count, bus.timeout_err); end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.dump_done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_hold got done=%b busy=%b exp 0/0", bus.dump_done, bus.busy); end
        end
        rst = 1'b0;
        clear_rec();
        mask = 3'b001; cbyte[0] = 8'hDA; clen[0] = 8;
        trig_q.push_back(0);
        run(20);
        got = '0;
        foreach (dbits[i]) if (i < 8) got[i] = dbits[i];
        checks++; if (cap_cnt != 1 || done_cnt != 1) begin errors++; $display("FAIL mid_rerun got cap=%0d done=%0d exp 1/1", cap_cnt, done_cnt); end
        checks++; if (bus.bit_count !== 16'd8 || got !== 8'hDA) begin errors++; $display("FAIL mid_rerun_stream got cnt=%0d bits=%h exp 8 bits=da", bus.bit_count, got); end
    endtask

    initial begin
        test_reset();
        test_two_chains();
        test_timeout();
        test_empty_mask();
        test_back_to_back();
        test_noise();
        test_rst_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
